// File: rtl/lab2_proc_test_mem_responder_pkg.sv
// Memory request/response message types for the lab2 test memory.
// Also holds the subword offset, byte-enable and read-mask helpers.
package lab2_proc_test_mem_responder_pkg;

  localparam logic [2:0] c_MEM_READ  = 3'd0;
  localparam logic [2:0] c_MEM_WRITE = 3'd1;
  localparam logic [2:0] c_MEM_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Byte offset inside the word; halfwords align down,
  // full words and 3-byte accesses start at byte 0.
  function automatic logic [1:0] sub_off(
    input logic [1:0] len,
    input logic [1:0] a
  );
    case (len)
      2'd1:    sub_off = a;
      2'd2:    sub_off = a & 2'b10;
      default: sub_off = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] sub_be(
    input logic [1:0] len,
    input logic [1:0] a
  );
    case (len)
      2'd0:    sub_be = 4'b1111;
      2'd1:    sub_be = 4'b0001 << sub_off(len, a);
      2'd2:    sub_be = 4'b0011 << sub_off(len, a);
      default: sub_be = 4'b0111;
    endcase
  endfunction

  function automatic logic [31:0] sub_mask(
    input logic [1:0] len
  );
    case (len)
      2'd0:    sub_mask = 32'hffff_ffff;
      2'd1:    sub_mask = 32'h0000_00ff;
      2'd2:    sub_mask = 32'h0000_ffff;
      default: sub_mask = 32'h00ff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/lab2_proc_test_mem_resp_buf.sv
// Response buffer: plain circular FIFO, enqueue visible next cycle.
// Never bypasses; the caller's credits keep it from overflowing.
module lab2_proc_test_mem_resp_buf
  import lab2_proc_test_mem_responder_pkg::*;
#(
  parameter int unsigned p_depth = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  input  mem_resp_4B_t enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output mem_resp_4B_t deq_msg
);

  localparam int unsigned AW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);

  mem_resp_4B_t  ent_q [p_depth];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq, deq;

  assign deq_val = (cnt_q != '0);
  assign deq_msg = ent_q[rp_q];
  assign deq     = deq_val && deq_rdy;
  assign enq     = enq_val && (cnt_q != CW'(p_depth));

  // Pointer wrap and occupancy update.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (enq) begin
      wp_d = (wp_q == AW'(p_depth - 1)) ? '0 : wp_q + AW'(1);
    end
    if (deq) begin
      rp_d = (rp_q == AW'(p_depth - 1)) ? '0 : rp_q + AW'(1);
    end
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  // Entry storage and pointers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(p_depth); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (enq) begin
        ent_q[wp_q] <= enq_msg;
      end
    end
  end

endmodule

// File: rtl/lab2_proc_test_mem_responder.sv
// Test-harness memory: word array, fixed-latency pipe, credited
// response buffer. Responses leave in request order.
module lab2_proc_test_mem_responder
  import lab2_proc_test_mem_responder_pkg::*;
#(
  parameter int unsigned p_mem_nbytes = 65536,
  parameter int unsigned p_latency    = 2,
  parameter int unsigned p_buf_depth  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  input  mem_req_4B_t  reqstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy,
  output mem_resp_4B_t respstream_msg
);

  localparam int unsigned AW = $clog2(p_mem_nbytes);
  localparam int unsigned NW = p_mem_nbytes / 4;
  localparam int unsigned CW = $clog2(p_buf_depth + 1);

  logic [31:0]   mem_q [NW];
  logic [AW-3:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata, rdata;
  logic          req_fire, resp_fire, is_wr;
  logic          live_q;
  logic [CW-1:0] cred_q, cred_d;
  mem_resp_4B_t  resp_d, enq_msg;
  logic          enq_val;
  logic          unused_addr;

  assign unused_addr = ^reqstream_msg.addr[31:AW];

  assign reqstream_rdy = live_q && (cred_q != '0);
  assign req_fire      = reqstream_val && reqstream_rdy;
  assign resp_fire     = respstream_val && respstream_rdy;

  assign idx   = reqstream_msg.addr[AW-1:2];
  assign off   = sub_off(reqstream_msg.len, reqstream_msg.addr[1:0]);
  assign be    = sub_be(reqstream_msg.len, reqstream_msg.addr[1:0]);
  assign is_wr = (reqstream_msg.type_ == c_MEM_WRITE)
              || (reqstream_msg.type_ == c_MEM_INIT);

  // Align write data to the byte lanes; right-justify read data.
  always_comb begin
    wdata = reqstream_msg.data << {off, 3'b000};
    rdata = (mem_q[idx] >> {off, 3'b000})
          & sub_mask(reqstream_msg.len);
  end

  // Response built in the accept cycle; only reads return data.
  always_comb begin
    resp_d        = '0;
    resp_d.type_  = reqstream_msg.type_;
    resp_d.opaque = reqstream_msg.opaque;
    resp_d.len    = reqstream_msg.len;
    if (reqstream_msg.type_ == c_MEM_READ) begin
      resp_d.data = rdata;
    end
  end

  // Storage survives reset; byte-enabled commit at accept edge.
  always_ff @(posedge clk) begin
    if (req_fire && is_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Hold rdy low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Credit change: one per accept, one back per response fired.
  always_comb begin
    cred_d = cred_q;
    unique case ({req_fire, resp_fire})
      2'b10:   cred_d = cred_q - CW'(1);
      2'b01:   cred_d = cred_q + CW'(1);
      default: ;
    endcase
  end

  // Credit register; full buffer budget after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cred_q <= CW'(p_buf_depth);
    end else begin
      cred_q <= cred_d;
    end
  end

  generate
    if (p_latency > 1) begin : g_pipe
      localparam int unsigned PS = p_latency - 1;
      logic [PS-1:0] pv_q;
      mem_resp_4B_t  pm_q [PS];

      // Fixed-delay shift pipe ahead of the buffer.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv_q <= '0;
          for (int i = 0; i < int'(PS); i++) begin
            pm_q[i] <= '0;
          end
        end else begin
          for (int i = int'(PS) - 1; i > 0; i--) begin
            pv_q[i] <= pv_q[i-1];
            pm_q[i] <= pm_q[i-1];
          end
          pv_q[0] <= req_fire;
          pm_q[0] <= resp_d;
        end
      end

      assign enq_val = pv_q[PS-1];
      assign enq_msg = pm_q[PS-1];
    end else begin : g_nopipe
      assign enq_val = req_fire;
      assign enq_msg = resp_d;
    end
  endgenerate

  lab2_proc_test_mem_resp_buf #(
    .p_depth (p_buf_depth)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_msg (enq_msg),
    .deq_val (respstream_val),
    .deq_rdy (respstream_rdy),
    .deq_msg (respstream_msg)
  );

endmodule

// File: tb/tb_lab2_proc_test_mem_responder.sv
// Bench for the lab2 test memory: directed steps then random traffic,
// checked each cycle against a byte-level memory and response queue.
module tb_lab2_proc_test_mem_responder;
  import lab2_proc_test_mem_responder_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 2;
  localparam int NB    = 65536;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         reqstream_val = 1'b0;
  logic         reqstream_rdy;
  mem_req_4B_t  reqstream_msg = '0;
  logic         respstream_val;
  logic         respstream_rdy = 1'b0;
  mem_resp_4B_t respstream_msg;

  lab2_proc_test_mem_responder #(
    .p_mem_nbytes (NB),
    .p_latency    (LAT),
    .p_buf_depth  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .reqstream_val  (reqstream_val),
    .reqstream_rdy  (reqstream_rdy),
    .reqstream_msg  (reqstream_msg),
    .respstream_val (respstream_val),
    .respstream_rdy (respstream_rdy),
    .respstream_msg (respstream_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_resp_4B_t msg;
    int           due;
  } exp_t;

  bit [7:0] mem [int unsigned];
  exp_t     oq [$];
  int       cyc = 0;
  bit       live = 1'b0;
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: got timeout expected progress", tag);
  endtask

  function automatic mem_req_4B_t mk(input logic [2:0] t,
                                     input logic [7:0] o,
                                     input logic [31:0] a,
                                     input logic [1:0] l,
                                     input logic [31:0] d);
    mem_req_4B_t m;
    m.type_  = t;
    m.opaque = o;
    m.addr   = a;
    m.len    = l;
    m.data   = d;
    return m;
  endfunction

  // Byte-addressed reference: n bytes starting at base.
  function automatic mem_resp_4B_t model(input mem_req_4B_t m);
    int unsigned a, base, n;
    mem_resp_4B_t r;
    a = m.addr % NB;
    n = (m.len == 2'd0) ? 4 : int'(m.len);
    case (m.len)
      2'd1:    base = a;
      2'd2:    base = a & ~32'd1;
      default: base = a & ~32'd3;
    endcase
    r.type_  = m.type_;
    r.opaque = m.opaque;
    r.test   = 2'd0;
    r.len    = m.len;
    r.data   = 32'd0;
    if (m.type_ == 3'd1 || m.type_ == 3'd2) begin
      for (int k = 0; k < int'(n); k++) begin
        mem[base + k] = m.data[8*k +: 8];
      end
    end else if (m.type_ == 3'd0) begin
      for (int k = 0; k < int'(n); k++) begin
        r.data = r.data | (32'(mem[base + k]) << (8 * k));
      end
    end
    return r;
  endfunction

  task automatic cycle(input logic v, input mem_req_4B_t m,
                       input logic rr, output logic acc);
    logic rdy_e, val_e;
    exp_t e;
    reqstream_val  = v;
    reqstream_msg  = m;
    respstream_rdy = rr;
    #1;
    rdy_e = live && (oq.size() < DEPTH);
    val_e = (oq.size() > 0) && (oq[0].due <= cyc);
    check("req_rdy", 64'(reqstream_rdy), 64'(rdy_e));
    check("resp_val", 64'(respstream_val), 64'(val_e));
    if (val_e) check("resp_msg", 64'(respstream_msg), 64'(oq[0].msg));
    acc = v && rdy_e;
    if (val_e && rr) void'(oq.pop_front());
    if (acc) begin
      e.msg = model(m);
      e.due = cyc + LAT;
      oq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input mem_req_4B_t m, input logic rr);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cycle(1'b1, m, rr, acc);
      n++;
    end
    if (!acc) timeout("send");
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (oq.size() > 0 && n < 100) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    if (oq.size() > 0) timeout("drain");
    cycle(1'b0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    reqstream_val  = 1'b0;
    respstream_rdy = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_req_rdy", 64'(reqstream_rdy), 64'd0);
    check("rst_resp_val", 64'(respstream_val), 64'd0);
    oq.delete();
    live = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    live = 1'b1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] hi;
    mem_req_4B_t m;
    int r;

    #2;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      send(mk(3'd2, 8'(i), 32'(i * 4), 2'd0, $urandom()), 1'b1);
    end
    drain();

    send(mk(3'd1, 8'h11, 32'h1000, 2'd0, 32'hdeadbeef), 1'b1);
    send(mk(3'd0, 8'h12, 32'h1000, 2'd0, 32'h0), 1'b1);
    drain();

    send(mk(3'd1, 8'h20, 32'h1000, 2'd0, 32'h11223344), 1'b1);
    send(mk(3'd1, 8'h21, 32'h1002, 2'd1, 32'h000000ab), 1'b1);
    send(mk(3'd0, 8'h22, 32'h1000, 2'd0, 32'h0), 1'b1);
    send(mk(3'd0, 8'h23, 32'h1002, 2'd2, 32'h0), 1'b1);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(mk(3'd0, 8'(i), 32'(4 * i), 2'd0, 32'h0), 1'b1);
    end
    drain();

    r = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(3'd0, 8'(8'h40 + r), 32'(4 * r), 2'd0, 32'h0),
            1'b0, acc);
      if (acc) r++;
    end
    drain();

    send(mk(3'd0, 8'h50, 32'h4, 2'd0, 32'h0), 1'b0);
    send(mk(3'd0, 8'h51, 32'h8, 2'd0, 32'h0), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);
    send(mk(3'd0, 8'h52, 32'h1000, 2'd0, 32'h0), 1'b1);
    drain();

    send(mk(3'd1, 8'h60, 32'h0, 2'd0, 32'h5), 1'b1);
    send(mk(3'd0, 8'h61, 32'h0001_0000, 2'd0, 32'h0), 1'b1);
    send(mk(3'd7, 8'h62, 32'h0, 2'd0, 32'h99), 1'b1);
    send(mk(3'd0, 8'h63, 32'h0, 2'd0, 32'h0), 1'b1);
    drain();

    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 9));
      hi = $urandom();
      m.type_  = (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : (r < 9) ? 3'd2
               : 3'(3 + $urandom_range(0, 4));
      m.opaque = 8'(i);
      m.addr   = {hi[31:16], 10'd0, 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3))};
      m.len    = 2'($urandom_range(0, 3));
      m.data   = $urandom();
      cycle($urandom_range(0, 3) != 0, m,
            $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
